// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, visible-window
// flag, frame tick and a one-pixel registered output stage for syncs and colour.
// Optional build macro: VGA_TEST_PATTERN_EN adds pattern_sel, which replaces the
// visible-window colour with eight vertical colour bars.
module vga_sync_gen #(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_tick,
    output logic        hSync,
    output logic        vSync,
    output logic [11:0] vga_rgb
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_DISPLAY + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_DISPLAY + V_FP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W   = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W   = 10'(V_SYNC);
    localparam logic [9:0] H_START    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_STOP     = 10'(H_SYNC + H_BP + H_DISPLAY - 1);
    localparam logic [9:0] V_START    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_STOP     = 10'(V_SYNC + V_BP + V_DISPLAY - 1);
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W      = 10'(H_DISPLAY / 8);
`endif

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [11:0]      rgb_q, rgb_d;

    logic             hs_raw;
    logic             vs_raw;
    logic [11:0]      pix_colour;
`ifdef VGA_TEST_PATTERN_EN
    logic [9:0]       h_off;
    logic [9:0]       bar;
`endif

    // Pixel-enable divider: free-running modulo-PIX_DIV counter.
    always_comb begin
        pix_en = (div_q == DIV_LAST);
        div_d  = pix_en ? '0 : div_q + 1'b1;
    end

    // Raster counters: h wraps at end of line and carries into v on the same pixel.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Visible window, frame tick and raw (pre-register) active-low syncs.
    always_comb begin
        bright     = (h_q >= H_START) && (h_q <= H_STOP) &&
                     (v_q >= V_START) && (v_q <= V_STOP);
        frame_tick = pix_en && (h_q == H_LAST) && (v_q == V_LAST);
        hs_raw     = ~(h_q < H_SYNC_W);
        vs_raw     = ~(v_q < V_SYNC_W);
    end

    // Colour for the current pixel; black whenever outside the visible window.
    always_comb begin
        pix_colour = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        h_off = h_q - H_START;
        bar   = h_off / BAR_W;
`endif
        if (bright) begin
            pix_colour = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
            if (pattern_sel) begin
                case (bar)
                    10'd0:   pix_colour = 12'hFFF;
                    10'd1:   pix_colour = 12'hFF0;
                    10'd2:   pix_colour = 12'h0FF;
                    10'd3:   pix_colour = 12'h0F0;
                    10'd4:   pix_colour = 12'hF0F;
                    10'd5:   pix_colour = 12'hF00;
                    10'd6:   pix_colour = 12'h00F;
                    default: pix_colour = 12'h000;
                endcase
            end
`endif
        end
    end

    // Output stage loads once per pixel so syncs and colour share the same latency.
    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        if (pix_en) begin
            hs_d  = hs_raw;
            vs_d  = vs_raw;
            rgb_d = pix_colour;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= 12'h000;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign hCount  = h_q;
    assign vCount  = v_q;
    assign hSync   = hs_q;
    assign vSync   = vs_q;
    assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so whole frames stay short.
// Reference: everything is derived from the count of clocks since reset release.
module tb_vga_sync_gen;

    localparam int unsigned PD  = 4;
    localparam int unsigned HS  = 8;
    localparam int unsigned HBP = 6;
    localparam int unsigned HD  = 32;
    localparam int unsigned HFP = 4;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = 3;
    localparam int unsigned VD  = 10;
    localparam int unsigned VFP = 2;
    localparam int unsigned HT  = HS + HBP + HD + HFP;
    localparam int unsigned VT  = VS + VBP + VD + VFP;
    localparam int unsigned FR  = HT * VT * PD;
    localparam int unsigned HST = HS + HBP;
    localparam int unsigned VST = VS + VBP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic        pat_sel = 1'b0;
    logic        pat_eff;
    logic [9:0]  hCount, vCount;
    logic        bright, pix_en, frame_tick, hSync, vSync;
    logic [11:0] vga_rgb;

    int vectors = 0;
    int miscompares = 0;

    vga_sync_gen #(
        .PIX_DIV(PD), .H_SYNC(HS), .H_BP(HBP), .H_DISPLAY(HD), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_DISPLAY(VD), .V_FP(VFP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rgb_in     (rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pat_sel),
`endif
        .hCount     (hCount),
        .vCount     (vCount),
        .bright     (bright),
        .pix_en     (pix_en),
        .frame_tick (frame_tick),
        .hSync      (hSync),
        .vSync      (vSync),
        .vga_rgb    (vga_rgb)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign pat_eff = pat_sel;
`else
    assign pat_eff = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: t = clocks since reset release; pixel index = t / PD.
    function automatic int unsigned f_h(input int unsigned tt);
        return (tt / PD) % HT;
    endfunction

    function automatic int unsigned f_v(input int unsigned tt);
        return (tt / PD / HT) % VT;
    endfunction

    function automatic bit f_pix(input int unsigned tt);
        return (tt % PD) == PD - 1;
    endfunction

    function automatic bit f_bright(input int unsigned h, input int unsigned v);
        return (h >= HST) && (h < HST + HD) && (v >= VST) && (v < VST + VD);
    endfunction

    function automatic bit f_tick(input int unsigned tt);
        return f_pix(tt) && f_h(tt) == HT - 1 && f_v(tt) == VT - 1;
    endfunction

    function automatic logic [11:0] f_bar(input int unsigned idx);
        logic [11:0] tbl [8];
        tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return tbl[idx];
    endfunction

    function automatic logic [11:0] f_colour(input int unsigned h, input int unsigned v,
                                             input logic [11:0] c, input logic sel);
        if (!f_bright(h, v)) return 12'h000;
        if (sel) return f_bar((h - HST) / (HD / 8));
        return c;
    endfunction

    int unsigned t;
    logic        exp_hs, exp_vs;
    logic [11:0] exp_rgb;

    // Pins show the previous pixel's syncs/colour, captured on each pixel boundary.
    always @(posedge clk) begin
        if (rst) begin
            t       <= 0;
            exp_hs  <= 1'b1;
            exp_vs  <= 1'b1;
            exp_rgb <= 12'h000;
        end else begin
            if (f_pix(t)) begin
                exp_hs  <= !(f_h(t) < HS);
                exp_vs  <= !(f_v(t) < VS);
                exp_rgb <= f_colour(f_h(t), f_v(t), rgb_in, pat_eff);
            end
            t <= t + 1;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rgb_in = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({hCount, vCount, bright, pix_en, frame_tick, hSync, vSync, vga_rgb} !==
                {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000}) begin
                miscompares++;
                $display("FAIL reset_state: got h=%0d v=%0d b=%b pe=%b ft=%b hs=%b vs=%b rgb=%h",
                         hCount, vCount, bright, pix_en, frame_tick, hSync, vSync, vga_rgb);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            vectors++;
            if (pix_en !== ((k % PD) == PD - 1)) begin
                miscompares++;
                $display("FAIL pix_en_cadence k=%0d: got %b want %b", k, pix_en,
                         (k % PD) == PD - 1);
            end
            if (k == PD) begin
                vectors++;
                if (hCount !== 10'd1) begin
                    miscompares++;
                    $display("FAIL first_hcount: got %0d want 1", hCount);
                end
            end
        end
    endtask

    task automatic test_line();
        int low = 0;
        int first_low = -1;
        int wraps = 0;
        logic [9:0] prev_h = '0;
        apply_reset();
        for (int k = 1; k < int'(HT * PD + PD); k++) begin
            @(negedge clk);
            if (!hSync) begin
                low++;
                if (first_low < 0) first_low = k;
            end
            if (prev_h == 10'(HT - 1) && hCount == 10'd0) begin
                wraps++;
                vectors++;
                if (vCount !== 10'd1) begin
                    miscompares++;
                    $display("FAIL line_wrap_vcount: got %0d want 1", vCount);
                end
            end
            prev_h = hCount;
        end
        vectors += 3;
        if (wraps != 1) begin
            miscompares++;
            $display("FAIL line_wrap_seen: got %0d want 1", wraps);
        end
        if (low != int'(HS * PD)) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d want %0d", low, HS * PD);
        end
        if (first_low != int'(PD)) begin
            miscompares++;
            $display("FAIL hsync_delay: got %0d want %0d", first_low, PD);
        end
    endtask

    task automatic test_frames();
        int ticks = 0;
        int vlow = 0;
        int t1 = -1;
        int t2 = -1;
        apply_reset();
        for (int k = 1; k <= int'(2 * FR + 2); k++) begin
            @(negedge clk);
            if (frame_tick) begin
                ticks++;
                if (ticks == 1) t1 = k;
                if (ticks == 2) t2 = k;
            end
            if (!vSync) vlow++;
        end
        vectors += 4;
        if (ticks != 2) begin
            miscompares++;
            $display("FAIL frame_tick_count: got %0d want 2", ticks);
        end
        if (t1 != int'(FR - 1)) begin
            miscompares++;
            $display("FAIL frame_tick_first: got %0d want %0d", t1, FR - 1);
        end
        if (t2 - t1 != int'(FR)) begin
            miscompares++;
            $display("FAIL frame_tick_period: got %0d want %0d", t2 - t1, FR);
        end
        if (vlow != int'(2 * VS * HT * PD)) begin
            miscompares++;
            $display("FAIL vsync_width: got %0d want %0d", vlow, 2 * VS * HT * PD);
        end
    endtask

    task automatic test_bright_window();
        int fh = -1, fv = -1, lh = -1, lv = -1;
        int red = 0;
        apply_reset();
        rgb_in = 12'hF00;
        for (int k = 1; k <= int'(FR + PD); k++) begin
            @(negedge clk);
            if (bright) begin
                if (fh < 0) begin
                    fh = int'(hCount);
                    fv = int'(vCount);
                end
                lh = int'(hCount);
                lv = int'(vCount);
            end
            if (vga_rgb == 12'hF00) red++;
            vectors++;
            if (vga_rgb !== exp_rgb) begin
                miscompares++;
                $display("FAIL bright_pin_rgb h=%0d v=%0d: got %h want %h",
                         hCount, vCount, vga_rgb, exp_rgb);
            end
        end
        vectors += 3;
        if (fh != int'(HST) || fv != int'(VST)) begin
            miscompares++;
            $display("FAIL bright_first: got (%0d,%0d) want (%0d,%0d)", fh, fv, HST, VST);
        end
        if (lh != int'(HST + HD - 1) || lv != int'(VST + VD - 1)) begin
            miscompares++;
            $display("FAIL bright_last: got (%0d,%0d) want (%0d,%0d)", lh, lv,
                     HST + HD - 1, VST + VD - 1);
        end
        if (red != int'(HD * VD * PD)) begin
            miscompares++;
            $display("FAIL red_pin_cycles: got %0d want %0d", red, HD * VD * PD);
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        apply_reset();
        rgb_in = 12'(($urandom & 12'hFFF) | 12'h001);
        for (int k = 0; k < int'(FR) && !found; k++) begin
            @(negedge clk);
            if (hCount == 10'(HT / 2) && vCount == 10'(VT / 2)) found = 1;
        end
        vectors += 2;
        if (!found) begin
            miscompares++;
            $display("FAIL midreset_reach: got 0 want 1");
        end
        if (vga_rgb !== exp_rgb) begin
            miscompares++;
            $display("FAIL midreset_pre_rgb: got %h want %h", vga_rgb, exp_rgb);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({hCount, vCount, hSync, vSync, vga_rgb, frame_tick} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_state: got h=%0d v=%0d hs=%b vs=%b rgb=%h ft=%b",
                     hCount, vCount, hSync, vSync, vga_rgb, frame_tick);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (frame_tick !== 1'b0 || hCount !== 10'(k / PD)) begin
                miscompares++;
                $display("FAIL midreset_resume k=%0d: got ft=%b h=%0d want ft=0 h=%0d",
                         k, frame_tick, hCount, k / PD);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            vectors++;
            if ({hCount, vCount, bright, pix_en, frame_tick, hSync, vSync, vga_rgb} !==
                {10'(f_h(t)), 10'(f_v(t)), f_bright(f_h(t), f_v(t)), f_pix(t), f_tick(t),
                 exp_hs, exp_vs, exp_rgb}) begin
                miscompares++;
                $display("FAIL random t=%0d: got h=%0d v=%0d b=%b pe=%b ft=%b hs=%b vs=%b rgb=%h want h=%0d v=%0d b=%b pe=%b ft=%b hs=%b vs=%b rgb=%h",
                         t, hCount, vCount, bright, pix_en, frame_tick, hSync, vSync, vga_rgb,
                         f_h(t), f_v(t), f_bright(f_h(t), f_v(t)), f_pix(t), f_tick(t),
                         exp_hs, exp_vs, exp_rgb);
            end
            rgb_in  = 12'($urandom);
            pat_sel = 1'($urandom);
            rst     = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
        pat_sel = 1'b0;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        apply_reset();
        pat_sel = 1'b1;
        rgb_in = 12'h0F0;
        for (int k = 1; k <= int'(FR); k++) begin
            @(negedge clk);
            vectors++;
            if (vga_rgb !== exp_rgb) begin
                miscompares++;
                $display("FAIL pattern_model h=%0d v=%0d: got %h want %h",
                         hCount, vCount, vga_rgb, exp_rgb);
            end
            if (vCount == 10'(VST + 1) && hCount == 10'(HST + 1)) begin
                vectors++;
                if (vga_rgb !== 12'hFFF) begin
                    miscompares++;
                    $display("FAIL pattern_bar0: got %h want FFF", vga_rgb);
                end
            end
            if (vCount == 10'(VST + 1) && hCount == 10'(HST + HD / 8 + 1)) begin
                vectors++;
                if (vga_rgb !== 12'hFF0) begin
                    miscompares++;
                    $display("FAIL pattern_bar1: got %h want FF0", vga_rgb);
                end
            end
            if (vCount == 10'(VST + 1) && hCount == 10'(HST + 7 * (HD / 8) + 1)) begin
                vectors++;
                if (vga_rgb !== 12'h000) begin
                    miscompares++;
                    $display("FAIL pattern_bar7: got %h want 000", vga_rgb);
                end
            end
        end
        pat_sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_bright_window();
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
